tia_horizontal_timing: RTL

Horizontal timing sequencer for the TIA model. Counts color clocks across a 228-clock scan line and generates:
- the line-phase enables;
- HSYNC, HBLANK and color-burst windows;
- the late-HBLANK extension requested by HMOVE;
- the CPU RDY release for WSYNC.

It sits between the register-strobe decoder and the object/playfield logic. All per-line latches (including every F1 stage) are clocked by its phase enables.

---
 rtl/tia_horizontal_timing_pkg.sv | 34 +++
 rtl/tia_hclk_div.sv | 34 +++
 rtl/tia_horizontal_timing.sv | 104 ++++++++++
 3 files changed

// File: rtl/tia_horizontal_timing_pkg.sv
// Shared horizontal timing constants, window record and decode helper for the TIA model.
package tia_horizontal_timing_pkg;

    typedef logic [7:0] cindex_t;
    typedef logic [1:0] phase_t;

    localparam int      TIA_LINE_CLOCKS  = 228;
    localparam cindex_t TIA_LAST_CINDEX  = cindex_t'(TIA_LINE_CLOCKS - 1);
    localparam cindex_t TIA_HSYNC_START  = 8'd16;
    localparam cindex_t TIA_HSYNC_END    = 8'd31;
    localparam cindex_t TIA_CBURST_START = 8'd32;
    localparam cindex_t TIA_CBURST_END   = 8'd47;
    localparam cindex_t TIA_HBLANK_END   = 8'd67;
    localparam cindex_t TIA_LHBLANK_END  = 8'd75;

    localparam phase_t  PHI1_PHASE = 2'd0;
    localparam phase_t  PHI2_PHASE = 2'd2;

    typedef struct packed {
        logic hsync;
        logic hblank;
        logic cburst;
    } h_windows_t;

    // Window levels for a given color-clock index; lhb widens the blank to the late edge.
    function automatic h_windows_t decode_windows(input cindex_t c, input logic lhb);
        h_windows_t w;
        w.hsync  = (c >= TIA_HSYNC_START) && (c <= TIA_HSYNC_END);
        w.cburst = (c >= TIA_CBURST_START) && (c <= TIA_CBURST_END);
        w.hblank = (c <= TIA_HBLANK_END) || (lhb && (c <= TIA_LHBLANK_END));
        return w;
    endfunction

endpackage

// File: rtl/tia_hclk_div.sv
// Divide-by-4 line phase counter; emits hphi1/hphi2 one-clock enables aligned to cindex.
module tia_hclk_div
    import tia_horizontal_timing_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic rsync,
    output logic hphi1,
    output logic hphi2
);

    phase_t phase;
    phase_t phase_next;

    // The line is 57 phases long, so the free-running phase always equals cindex%4.
    always_comb begin
        phase_next = phase + 2'd1;
        if (rsync) phase_next = PHI1_PHASE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= PHI1_PHASE;
            hphi1 <= 1'b1;
            hphi2 <= 1'b0;
        end else begin
            phase <= phase_next;
            hphi1 <= (phase_next == PHI1_PHASE);
            hphi2 <= (phase_next == PHI2_PHASE);
        end
    end

endmodule

// File: rtl/tia_horizontal_timing.sv
// TIA horizontal sequencer: line counter, sync/blank/burst windows, late HBLANK and WSYNC release.
module tia_horizontal_timing
    import tia_horizontal_timing_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       rsync,
    input  logic       wsync,
    input  logic       hmove,
    output logic [7:0] cindex,
    output logic [5:0] hcount,
    output logic       hphi1,
    output logic       hphi2,
    output logic       hsync,
    output logic       hblank,
    output logic       cburst,
    output logic       motck_en,
    output logic       rdy
);

    cindex_t    cindex_next;
    logic       line_start;
    logic       lhb_pending;
    logic       lhb_active;
    logic       lhb_pending_next;
    logic       lhb_active_next;
    logic       quick_release;
    logic       quick_release_next;
    logic       rdy_next;
    logic       wsync_take;
    h_windows_t win_next;

    tia_hclk_div u_hclk_div (
        .clock (clock),
        .reset (reset),
        .rsync (rsync),
        .hphi1 (hphi1),
        .hphi2 (hphi2)
    );

    assign hcount = cindex[7:2];

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        cindex_next = cindex + 8'd1;
        if (rsync || (cindex == TIA_LAST_CINDEX)) cindex_next = '0;
        line_start = (cindex_next == 8'd0);
    end

    // An HMOVE on the line-start clock (natural wrap or RSYNC) lands on the line now starting.
    always_comb begin
        lhb_active_next  = lhb_active;
        lhb_pending_next = lhb_pending;
        if (line_start) begin
            lhb_active_next  = lhb_pending | hmove;
            lhb_pending_next = 1'b0;
        end else if (hmove) begin
            if (cindex <= TIA_HBLANK_END) lhb_active_next  = 1'b1;
            else                          lhb_pending_next = 1'b1;
        end
    end

    // A WSYNC coinciding with a natural wrap releases one clock later instead of a full line later.
    always_comb begin
        wsync_take         = wsync && rdy;
        rdy_next           = rdy;
        quick_release_next = 1'b0;
        if (wsync_take) begin
            rdy_next           = 1'b0;
            quick_release_next = line_start && !rsync;
        end else if (quick_release || line_start) begin
            rdy_next = 1'b1;
        end
    end

    always_comb begin
        win_next = decode_windows(cindex_next, lhb_active_next);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cindex        <= '0;
            lhb_pending   <= 1'b0;
            lhb_active    <= 1'b0;
            quick_release <= 1'b0;
            rdy           <= 1'b1;
            hsync         <= 1'b0;
            hblank        <= 1'b1;
            cburst        <= 1'b0;
            motck_en      <= 1'b0;
        end else begin
            cindex        <= cindex_next;
            lhb_pending   <= lhb_pending_next;
            lhb_active    <= lhb_active_next;
            quick_release <= quick_release_next;
            rdy           <= rdy_next;
            hsync         <= win_next.hsync;
            hblank        <= win_next.hblank;
            cburst        <= win_next.cburst;
            motck_en      <= ~win_next.hblank;
        end
    end

endmodule
